my_interface_blk: RTL and testbench

MY_INTERFACE_BLK -- requirements
Module: my_interface_blk

---
 rtl/my_interface_pkg.sv | 16 +
 rtl/delay_counter.sv | 33 +++
 rtl/my_interface_blk.sv | 126 ++++++++++++
 tb/tb_my_interface_blk.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_interface_pkg.sv
// Shared definitions for the burst interface block: FSM state encoding
// and the default parameter values used by the top and its testbench.
package my_interface_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_W      = 8;
    localparam int DEFAULT_START_DELAY = 10;
    localparam int DEFAULT_NUM_BEATS   = 10;

endpackage

// File: rtl/delay_counter.sv
// Start-delay counter: cleared by load, advances while count is high and
// raises expired once START_DELAY counted cycles have elapsed.
module delay_counter
    import my_interface_pkg::*;
#(
    parameter int START_DELAY = DEFAULT_START_DELAY
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expired
);

    localparam logic [7:0] LAST_COUNT = 8'(START_DELAY - 1);

    logic [7:0] cnt;

    // expired is high during the final cycle of the wait window
    assign expired = (cnt == LAST_COUNT);

    // Counter clears on load and saturates at the last count value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= 8'd0;
        end else if (count && !expired) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/my_interface_blk.sv
// Burst generator: after an accepted start and a fixed idle delay, streams
// NUM_BEATS incrementing payload words under valid/ready handshaking and
// pulses done once the final beat has been accepted.
module my_interface_blk
    import my_interface_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int START_DELAY = DEFAULT_START_DELAY,
    parameter int NUM_BEATS   = DEFAULT_NUM_BEATS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              busy,
    output logic              done,
    output logic [7:0]        beat_cnt
);

    localparam logic [8:0] BEATS_TOTAL = 9'(NUM_BEATS);

    state_t state;
    state_t next_state;
    logic   delay_load;
    logic   delay_count;
    logic   delay_expired;
    logic   transfer;
    logic   last_beat;

    delay_counter #(
        .START_DELAY(START_DELAY)
    ) u_delay_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (delay_load),
        .count  (delay_count),
        .expired(delay_expired)
    );

    assign transfer  = valid && ready;
    assign last_beat = (({1'b0, beat_cnt} + 9'd1) == BEATS_TOTAL);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and delay counter control
    always_comb begin
        next_state  = state;
        delay_load  = 1'b0;
        delay_count = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = WAIT;
                    delay_load = 1'b1;
                end
            end
            WAIT: begin
                delay_count = 1'b1;
                if (delay_expired) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (transfer && last_beat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Registered payload, qualifier and beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data     <= '0;
            valid    <= 1'b0;
            beat_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        data     <= '0;
                        beat_cnt <= 8'd0;
                        valid    <= 1'b0;
                    end
                end
                WAIT: begin
                    if (delay_expired) begin
                        data  <= DATA_W'(1);
                        valid <= 1'b1;
                    end
                end
                STREAM: begin
                    if (transfer) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (last_beat) begin
                            valid <= 1'b0;
                        end else begin
                            data <= data + DATA_W'(1);
                        end
                    end
                end
                default: begin
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_my_interface_blk.sv
// Directed testbench for my_interface_blk: three instances with different
// parameter sets share clock, reset and ready; start is steered to one
// selected instance at a time.
module tb_my_interface_blk;

    logic clk;
    logic rst_n;
    logic start;
    logic ready;
    int   sel;

    logic       start_a, start_b, start_c;
    logic [7:0] data_a;
    logic [1:0] data_b;
    logic [7:0] data_c;
    logic       valid_a, valid_b, valid_c;
    logic       busy_a, busy_b, busy_c;
    logic       done_a, done_b, done_c;
    logic [7:0] beat_a, beat_b, beat_c;

    logic [7:0] cur_data;
    logic       cur_valid;
    logic       cur_busy;
    logic       cur_done;
    logic [7:0] cur_beat;

    int total;
    int bad;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    // defaults: DATA_W=8, START_DELAY=10, NUM_BEATS=10
    my_interface_blk u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_a),
        .ready   (ready),
        .data    (data_a),
        .valid   (valid_a),
        .busy    (busy_a),
        .done    (done_a),
        .beat_cnt(beat_a)
    );

    // narrow payload to exercise wrap-around
    my_interface_blk #(.DATA_W(2), .START_DELAY(3), .NUM_BEATS(6)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_b),
        .ready   (ready),
        .data    (data_b),
        .valid   (valid_b),
        .busy    (busy_b),
        .done    (done_b),
        .beat_cnt(beat_b)
    );

    // minimum delay and burst length
    my_interface_blk #(.DATA_W(8), .START_DELAY(1), .NUM_BEATS(1)) u_dut_c (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_c),
        .ready   (ready),
        .data    (data_c),
        .valid   (valid_c),
        .busy    (busy_c),
        .done    (done_c),
        .beat_cnt(beat_c)
    );

    // Observe the currently selected instance
    always_comb begin
        cur_data  = data_a;
        cur_valid = valid_a;
        cur_busy  = busy_a;
        cur_done  = done_a;
        cur_beat  = beat_a;
        if (sel == 1) begin
            cur_data  = {6'b0, data_b};
            cur_valid = valid_b;
            cur_busy  = busy_b;
            cur_done  = done_b;
            cur_beat  = beat_b;
        end else if (sel == 2) begin
            cur_data  = data_c;
            cur_valid = valid_c;
            cur_busy  = busy_c;
            cur_done  = done_c;
            cur_beat  = beat_c;
        end
    end

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and return at the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Launch one burst on the selected instance and check it end to end.
    // toggle_ready alternates ready during STREAM; start_noise keeps start
    // high throughout WAIT and STREAM.
    task automatic applyStimulus(input int delay, input int beats, input int mask,
                                 input bit toggle_ready, input bit start_noise);
        int  cycles;
        int  xfer;
        int  dones;
        int  budget;
        bit  held_pending;
        int  held_data;
        bit  saw_done;

        start = 1'b1;
        ready = 1'b1;
        tick();
        start = start_noise;
        checkOutput("busy_after_start", int'(cur_busy), 1);
        checkOutput("data_cleared", int'(cur_data), 0);
        checkOutput("beat_cleared", int'(cur_beat), 0);

        cycles = 0;
        while (!cur_valid && cycles < delay + 5) begin
            if (cur_done) checkOutput("done_in_wait", int'(cur_done), 0);
            tick();
            cycles++;
        end
        checkOutput("start_delay", cycles, delay);

        xfer         = 0;
        dones        = 0;
        held_pending = 1'b0;
        held_data    = 0;
        saw_done     = 1'b0;
        budget       = 4 * beats + 20;
        for (int i = 0; i < budget && !saw_done; i++) begin
            ready = toggle_ready ? ((i % 2) == 0) : 1'b1;
            if (held_pending) begin
                checkOutput("hold_data", int'(cur_data), held_data);
                checkOutput("hold_valid", int'(cur_valid), 1);
                held_pending = 1'b0;
            end
            if (cur_valid && ready) begin
                xfer++;
                checkOutput("beat_data", int'(cur_data), xfer & mask);
                checkOutput("beat_count", int'(cur_beat), xfer - 1);
            end else if (cur_valid) begin
                held_pending = 1'b1;
                held_data    = int'(cur_data);
            end
            tick();
            if (cur_done) begin
                dones++;
                saw_done = 1'b1;
                start    = 1'b0;
                checkOutput("valid_in_done", int'(cur_valid), 0);
            end
        end
        checkOutput("done_seen", int'(saw_done), 1);
        checkOutput("transfers", xfer, beats);
        checkOutput("final_beat_cnt", int'(cur_beat), beats);
        checkOutput("final_data", int'(cur_data), beats & mask);
        checkOutput("busy_in_done", int'(cur_busy), 1);

        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (cur_done) dones++;
        end
        checkOutput("done_pulses", dones, 1);
        checkOutput("idle_busy", int'(cur_busy), 0);
        checkOutput("idle_valid", int'(cur_valid), 0);
        checkOutput("retain_data", int'(cur_data), beats & mask);
        checkOutput("retain_beat", int'(cur_beat), beats);
    endtask

    initial begin
        int cycles;
        int dones;

        total = 0;
        bad   = 0;
        sel   = 0;
        start = 1'b0;
        ready = 1'b1;
        rst_n = 1'b0;

        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #0;
            checkOutput("reset_data", int'(cur_data), 0);
            checkOutput("reset_valid", int'(cur_valid), 0);
            checkOutput("reset_busy", int'(cur_busy), 0);
            checkOutput("reset_done", int'(cur_done), 0);
            checkOutput("reset_beat", int'(cur_beat), 0);
        end
        sel   = 0;
        rst_n = 1'b1;

        $display("[TB] basic burst, ready high");
        applyStimulus(10, 10, 255, 1'b0, 1'b0);

        $display("[TB] burst with ready toggling");
        applyStimulus(10, 10, 255, 1'b1, 1'b0);

        $display("[TB] start held during WAIT and STREAM");
        applyStimulus(10, 10, 255, 1'b0, 1'b1);

        $display("[TB] reset asserted mid-stream");
        start = 1'b1;
        ready = 1'b1;
        tick();
        start  = 1'b0;
        cycles = 0;
        while (!cur_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        checkOutput("abort_delay", cycles, 10);
        repeat (4) tick();
        checkOutput("abort_pre_beat", int'(cur_beat), 4);
        checkOutput("abort_pre_data", int'(cur_data), 5);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_data", int'(cur_data), 0);
        checkOutput("async_valid", int'(cur_valid), 0);
        checkOutput("async_busy", int'(cur_busy), 0);
        checkOutput("async_beat", int'(cur_beat), 0);
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (cur_done) dones++;
        end
        rst_n = 1'b1;
        checkOutput("abort_no_done", dones, 0);
        applyStimulus(10, 10, 255, 1'b0, 1'b0);

        $display("[TB] narrow payload wrap-around");
        sel = 1;
        applyStimulus(3, 6, 3, 1'b0, 1'b0);

        $display("[TB] single beat, single cycle delay");
        sel = 2;
        applyStimulus(1, 1, 255, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
